// File: rtl/di_pfb_pkg.sv
// Shared types and constants for the dual-issue prefetch-buffer line buffer.
package di_pfb_pkg;

   localparam int unsigned HW_PER_LINE = 8;
   localparam int unsigned LINE_BYTES  = 16;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StAbort
   } pfb_fetch_state_e;

   typedef logic [3:0][31:0] pfb_line_t;

   // A 16-bit parcel starts a compressed instruction unless its low two bits are 2'b11.
   function automatic logic is_compressed(input logic [15:0] hw);
      return (hw & 16'h0003) != 16'h0003;
   endfunction

endpackage

// File: rtl/di_pfb_fetch_fsm.sv
// Line fetch sequencer: one outstanding request, branch abort handling and the line address counter.
module di_pfb_fetch_fsm
   import di_pfb_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0080
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  slot_free,
   input  logic                  branch,
   input  logic [ADDR_WIDTH-1:0] branch_addr,
   output logic                  instr_req_o,
   output logic [ADDR_WIDTH-1:0] instr_addr_o,
   input  logic                  instr_gnt_i,
   input  logic                  instr_rvalid_i,
   output logic                  line_valid
);

   localparam logic [ADDR_WIDTH-1:0] LineBytes = ADDR_WIDTH'(LINE_BYTES);
   localparam logic [ADDR_WIDTH-1:0] LineMask  = ~(LineBytes - ADDR_WIDTH'(1));

   pfb_fetch_state_e      state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         fetch_addr_q <= BOOT_ADDR & LineMask;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      unique case (state_q)
         StIdle: begin
            if (!branch && slot_free) state_d = StReq;
         end
         StReq: begin
            // A grant coinciding with a branch still owes us a response that must be dropped.
            if (branch)           state_d = instr_gnt_i ? StAbort : StIdle;
            else if (instr_gnt_i) state_d = StWait;
         end
         StWait: begin
            if (branch) begin
               state_d = instr_rvalid_i ? StIdle : StAbort;
            end else if (instr_rvalid_i) begin
               state_d      = StIdle;
               fetch_addr_d = fetch_addr_q + LineBytes;
            end
         end
         StAbort: begin
            if (instr_rvalid_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (branch) fetch_addr_d = branch_addr & LineMask;
   end

   always_comb begin
      instr_req_o  = (state_q == StReq);
      instr_addr_o = instr_req_o ? fetch_addr_q : '0;
      line_valid   = (state_q == StWait) && instr_rvalid_i && !branch;
   end

endmodule

// File: rtl/di_pfb_line_buf.sv
// Two-line prefetch buffer feeding the primary issue slot: current line, one prefetched line,
// half-word index tracking with wrap into the next line.
module di_pfb_line_buf
   import di_pfb_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0080
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  instr_req_o,
   output logic [ADDR_WIDTH-1:0] instr_addr_o,
   input  logic                  instr_gnt_i,
   input  logic                  instr_rvalid_i,
   input  logic [127:0]          instr_rdata_i,
   input  logic                  branch_i,
   input  logic [ADDR_WIDTH-1:0] branch_addr_i,
   input  logic                  issue_fire_i,
   output logic [3:0][31:0]      instr_buf,
   output logic [2:0]            pi_hw_idx,
   output logic                  pi_hw_idx_valid,
   output logic [15:0]           pi_straddle_hw,
   input  logic [2:0]            next_hw_idx,
   input  logic                  i2_instr_allocated
);

   localparam logic [2:0] LastHw = 3'(HW_PER_LINE - 1);

   pfb_line_t  cur_q, cur_d, nxt_q, nxt_d;
   logic       cur_valid_q, cur_valid_d, nxt_valid_q, nxt_valid_d;
   logic [2:0] idx_q, idx_d;
   logic       slot_free, line_valid, advance, wrap;

   di_pfb_fetch_fsm #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .BOOT_ADDR (BOOT_ADDR)
   ) u_fetch_fsm (
      .clk           (clk),
      .rst           (rst),
      .slot_free     (slot_free),
      .branch        (branch_i),
      .branch_addr   (branch_addr_i),
      .instr_req_o   (instr_req_o),
      .instr_addr_o  (instr_addr_o),
      .instr_gnt_i   (instr_gnt_i),
      .instr_rvalid_i(instr_rvalid_i),
      .line_valid    (line_valid)
   );

   assign slot_free = !cur_valid_q || !nxt_valid_q;

   // A 32-bit instruction in the last half-word needs the next line's half-word 0.
   assign pi_hw_idx_valid = cur_valid_q && !branch_i &&
                            ((idx_q != LastHw) || is_compressed(cur_q[3][31:16]) || nxt_valid_q);

   assign advance = issue_fire_i && pi_hw_idx_valid;
   // Issue consumes at most four half-words, so a non-increasing index means a line crossing.
   assign wrap    = advance && (next_hw_idx <= idx_q);

   always_comb begin
      cur_d       = cur_q;
      nxt_d       = nxt_q;
      cur_valid_d = cur_valid_q;
      nxt_valid_d = nxt_valid_q;
      idx_d       = idx_q;
      if (branch_i) begin
         cur_valid_d = 1'b0;
         nxt_valid_d = 1'b0;
         idx_d       = branch_addr_i[3:1];
      end else begin
         if (advance) idx_d = next_hw_idx;
         if (wrap) begin
            cur_d       = nxt_q;
            cur_valid_d = nxt_valid_q;
            nxt_valid_d = 1'b0;
         end
         // Placement looks at the post-wrap occupancy so a line returning during a wrap lands
         // in the slot the wrap just freed.
         if (line_valid) begin
            if (!cur_valid_d) begin
               cur_d       = instr_rdata_i;
               cur_valid_d = 1'b1;
            end else begin
               nxt_d       = instr_rdata_i;
               nxt_valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_q       <= '0;
         nxt_q       <= '0;
         cur_valid_q <= 1'b0;
         nxt_valid_q <= 1'b0;
         idx_q       <= '0;
      end else begin
         cur_q       <= cur_d;
         nxt_q       <= nxt_d;
         cur_valid_q <= cur_valid_d;
         nxt_valid_q <= nxt_valid_d;
         idx_q       <= idx_d;
      end
   end

   assign instr_buf      = cur_q;
   assign pi_hw_idx      = idx_q;
   assign pi_straddle_hw = nxt_q[0][15:0];

   fire_needs_valid: assert property (@(posedge clk) disable iff (rst)
      !(issue_fire_i && !branch_i && !pi_hw_idx_valid));

   // Two instructions always span at least two half-words.
   pair_moves_index: assert property (@(posedge clk) disable iff (rst)
      (issue_fire_i && i2_instr_allocated && !branch_i) |-> (next_hw_idx != pi_hw_idx));

endmodule

// File: tb/tb_di_pfb_line_buf.sv
// Randomized bench: memory responder, line-stream reference model and a per-cycle scoreboard.
module tb_di_pfb_line_buf;

   localparam logic [31:0] BOOT = 32'h0000_0080;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             instr_req_o;
   logic [31:0]      instr_addr_o;
   logic             instr_gnt_i = 1'b0;
   logic             instr_rvalid_i = 1'b0;
   logic [127:0]     instr_rdata_i = '0;
   logic             branch_i = 1'b0;
   logic [31:0]      branch_addr_i = '0;
   logic             issue_fire_i = 1'b0;
   logic [3:0][31:0] instr_buf;
   logic [2:0]       pi_hw_idx;
   logic             pi_hw_idx_valid;
   logic [15:0]      pi_straddle_hw;
   logic [2:0]       next_hw_idx = '0;
   logic             i2_instr_allocated = 1'b0;

   always #5 clk = ~clk;

   di_pfb_line_buf #(
      .ADDR_WIDTH(32),
      .BOOT_ADDR (BOOT)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .instr_req_o       (instr_req_o),
      .instr_addr_o      (instr_addr_o),
      .instr_gnt_i       (instr_gnt_i),
      .instr_rvalid_i    (instr_rvalid_i),
      .instr_rdata_i     (instr_rdata_i),
      .branch_i          (branch_i),
      .branch_addr_i     (branch_addr_i),
      .issue_fire_i      (issue_fire_i),
      .instr_buf         (instr_buf),
      .pi_hw_idx         (pi_hw_idx),
      .pi_hw_idx_valid   (pi_hw_idx_valid),
      .pi_straddle_hw    (pi_straddle_hw),
      .next_hw_idx       (next_hw_idx),
      .i2_instr_allocated(i2_instr_allocated)
   );

   typedef struct {
      logic         valid;
      logic [2:0]   idx;
      int           held;
      logic [127:0] buf_line;
      logic [15:0]  straddle;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: the buffer is a window onto the line stream starting at stream_addr.
   logic [31:0] stream_addr;
   int          held;
   logic [2:0]  idx;
   logic        pend_active, pend_stale;
   logic [31:0] pend_addr;
   int          pend_cnt;

   function automatic logic [127:0] mem_line(input logic [31:0] a);
      logic [127:0] l;
      logic [31:0]  x;
      l = '0;
      for (int k = 0; k < 8; k++) begin
         x = (a * 32'h9E37_79B1) ^ (32'(k) * 32'h85EB_CA6B);
         x = x ^ (x >> 16) ^ (x >> 7);
         l[16*k +: 16] = x[15:0];
      end
      return l;
   endfunction

   function automatic logic model_valid(input logic br);
      logic [127:0] l;
      l = mem_line(stream_addr);
      return (held >= 1) && !br && ((idx != 3'd7) || (l[113:112] != 2'b11) || (held >= 2));
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("valid", {127'd0, pi_hw_idx_valid}, {127'd0, e.valid});
         check("idx", {125'd0, pi_hw_idx}, {125'd0, e.idx});
         if (e.held >= 1) check("cur_line", instr_buf, e.buf_line);
         if (e.held >= 2) check("straddle", {112'd0, pi_straddle_hw}, {112'd0, e.straddle});
      end
   end

   task automatic model_reset();
      stream_addr = BOOT & ~32'hF;
      held        = 0;
      idx         = 3'd0;
      pend_active = 1'b0;
      pend_stale  = 1'b0;
      pend_addr   = '0;
      pend_cnt    = 0;
   endtask

   // One clock cycle: memory side, issue side, expected outputs, then model update at the edge.
   task automatic cycle(input logic br, input logic [31:0] baddr, input logic want_fire);
      logic         gnt, rv, mv, fire, i2, deliver;
      logic [31:0]  a;
      logic [2:0]   nidx;
      logic [127:0] nl;
      int           adv;
      exp_t         e;
      a   = instr_addr_o;
      rv  = pend_active && (pend_cnt == 0);
      gnt = instr_req_o && ($urandom_range(0, 3) != 0);
      if (gnt) check("req_addr", {96'd0, a}, {96'd0, stream_addr + 32'(16 * held)});
      instr_gnt_i    = gnt;
      instr_rvalid_i = rv;
      instr_rdata_i  = rv ? mem_line(pend_addr) : {$urandom, $urandom, $urandom, $urandom};
      mv   = model_valid(br);
      fire = want_fire && (mv || br);
      adv  = $urandom_range(1, 4);
      nidx = 3'((int'(idx) + adv) % 8);
      i2   = fire ? ((adv >= 2) && ($urandom_range(0, 1) == 1)) : ($urandom_range(0, 1) == 1);
      branch_i           = br;
      branch_addr_i      = baddr;
      issue_fire_i       = fire;
      next_hw_idx        = nidx;
      i2_instr_allocated = i2;
      nl         = mem_line(stream_addr + 32'd16);
      e.valid    = mv;
      e.idx      = idx;
      e.held     = held;
      e.buf_line = mem_line(stream_addr);
      e.straddle = nl[15:0];
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      deliver = 1'b0;
      if (rv) begin
         pend_active = 1'b0;
         deliver     = !pend_stale && !br;
      end else if (pend_active) begin
         pend_cnt--;
         if (br) pend_stale = 1'b1;
      end
      if (gnt) begin
         pend_active = 1'b1;
         pend_stale  = br;
         pend_addr   = a;
         pend_cnt    = $urandom_range(0, 2);
      end
      if (br) begin
         held        = 0;
         idx         = baddr[3:1];
         stream_addr = baddr & ~32'hF;
      end else begin
         if (fire) begin
            if (int'(idx) + adv >= 8) begin
               stream_addr = stream_addr + 32'd16;
               held--;
            end
            idx = nidx;
         end
         if (deliver) held++;
      end
   endtask

   task automatic run_random(input int n, input int directed_at);
      logic        br;
      logic [31:0] baddr;
      for (int i = 0; i < n; i++) begin
         br    = (i == directed_at) || ($urandom_range(0, 99) < 3);
         baddr = (i == directed_at) ? 32'h0000_1006 : ($urandom & 32'h0000_3FFE);
         cycle(br, baddr, $urandom_range(0, 9) < 7);
      end
   endtask

   initial begin : stim
      int n;
      model_reset();
      #12;
      check("rst_req", {127'd0, instr_req_o}, 128'd0);
      check("rst_addr", {96'd0, instr_addr_o}, 128'd0);
      check("rst_valid", {127'd0, pi_hw_idx_valid}, 128'd0);
      check("rst_idx", {125'd0, pi_hw_idx}, 128'd0);
      check("rst_buf", instr_buf, 128'd0);
      check("rst_straddle", {112'd0, pi_straddle_hw}, 128'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("boot_req", {127'd0, instr_req_o}, 128'd1);
      check("boot_addr", {96'd0, instr_addr_o}, {96'd0, BOOT});

      run_random(600, 150);

      // Bring a fetch into flight, then reset in the middle of the cycle.
      n = 0;
      while (!pend_active && n < 50) begin
         cycle(1'b0, 32'd0, $urandom_range(0, 1) == 1);
         n++;
      end
      check("reach_wait", {127'd0, pend_active}, 128'd1);
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      branch_i       = 1'b0;
      issue_fire_i   = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async_req", {127'd0, instr_req_o}, 128'd0);
      check("async_addr", {96'd0, instr_addr_o}, 128'd0);
      check("async_valid", {127'd0, pi_hw_idx_valid}, 128'd0);
      check("async_idx", {125'd0, pi_hw_idx}, 128'd0);
      check("async_buf", instr_buf, 128'd0);
      check("async_straddle", {112'd0, pi_straddle_hw}, 128'd0);
      @(posedge clk);
      #1;
      rst            = 1'b0;
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = {$urandom, $urandom, $urandom, $urandom};
      model_reset();
      @(posedge clk);
      #1;
      instr_rvalid_i = 1'b0;
      check("late_rvalid_valid", {127'd0, pi_hw_idx_valid}, 128'd0);
      check("refetch_req", {127'd0, instr_req_o}, 128'd1);
      check("refetch_addr", {96'd0, instr_addr_o}, {96'd0, BOOT});

      run_random(400, 200);

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
